// File: rtl/des_pkg.sv
// des_pkg: shared constants and helpers for the pipelined DES round function.
//   E_TABLE    - DES expansion table, 48 entries, 1-based DES bit numbers
//   P_TABLE    - DES P permutation table, 32 entries, 1-based DES bit numbers
//   des_expand - 32 -> 48 bit E-expansion
//   des_perm_p - 32 -> 32 bit P permutation
// Vectors are MSB-first: vector bit (W-n) holds DES bit n.
package des_pkg;

    localparam int R_W = 32;
    localparam int K_W = 48;

    localparam int E_TABLE [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int P_TABLE [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    // Output DES bit j+1 takes input DES bit E_TABLE[j].
    function automatic logic [K_W-1:0] des_expand(input logic [R_W-1:0] r);
        logic [K_W-1:0] e;
        e = '0;
        for (int j = 0; j < K_W; j++) begin
            e[K_W-1-j] = r[R_W-E_TABLE[j]];
        end
        return e;
    endfunction

    // Output DES bit j+1 takes input DES bit P_TABLE[j].
    function automatic logic [R_W-1:0] des_perm_p(input logic [R_W-1:0] s);
        logic [R_W-1:0] p;
        p = '0;
        for (int j = 0; j < R_W; j++) begin
            p[R_W-1-j] = s[R_W-P_TABLE[j]];
        end
        return p;
    endfunction

endpackage

// File: rtl/des_sbox_layer.sv
// des_sbox_layer: combinational S-box substitution layer of the DES f function.
//   x_i [47:0] - expanded-and-keyed value; sbox i gets x_i[47-6(i-1) -: 6]
//   s_o [31:0] - concatenated S-box outputs, sbox1 at [31:28], sbox8 at [3:0]
// The S-box modules sbox1..sbox8 follow in this file.
module des_sbox_layer (
    input  logic [47:0] x_i,
    output logic [31:0] s_o
);

    sbox1 uSbox1 (.b_i(x_i[47:42]), .s_o(s_o[31:28]));
    sbox2 uSbox2 (.b_i(x_i[41:36]), .s_o(s_o[27:24]));
    sbox3 uSbox3 (.b_i(x_i[35:30]), .s_o(s_o[23:20]));
    sbox4 uSbox4 (.b_i(x_i[29:24]), .s_o(s_o[19:16]));
    sbox5 uSbox5 (.b_i(x_i[23:18]), .s_o(s_o[15:12]));
    sbox6 uSbox6 (.b_i(x_i[17:12]), .s_o(s_o[11:8]));
    sbox7 uSbox7 (.b_i(x_i[11:6]),  .s_o(s_o[7:4]));
    sbox8 uSbox8 (.b_i(x_i[5:0]),   .s_o(s_o[3:0]));

endmodule

// Each S-box table holds its four rows back to back, one nibble per entry,
// entry 0 first. The lookup address is {row, column} = {b5, b0, b4..b1}.
module sbox1 (
    input  logic [5:0] b_i,
    output logic [3:0] s_o
);
    localparam logic [0:63][3:0] TABLE = {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
                                          64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D};
    logic [5:0] addr;
    assign addr = {b_i[5], b_i[0], b_i[4:1]};
    assign s_o  = TABLE[addr];
endmodule

module sbox2 (
    input  logic [5:0] b_i,
    output logic [3:0] s_o
);
    localparam logic [0:63][3:0] TABLE = {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
                                          64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9};
    logic [5:0] addr;
    assign addr = {b_i[5], b_i[0], b_i[4:1]};
    assign s_o  = TABLE[addr];
endmodule

module sbox3 (
    input  logic [5:0] b_i,
    output logic [3:0] s_o
);
    localparam logic [0:63][3:0] TABLE = {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
                                          64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C};
    logic [5:0] addr;
    assign addr = {b_i[5], b_i[0], b_i[4:1]};
    assign s_o  = TABLE[addr];
endmodule

module sbox4 (
    input  logic [5:0] b_i,
    output logic [3:0] s_o
);
    localparam logic [0:63][3:0] TABLE = {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
                                          64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E};
    logic [5:0] addr;
    assign addr = {b_i[5], b_i[0], b_i[4:1]};
    assign s_o  = TABLE[addr];
endmodule

module sbox5 (
    input  logic [5:0] b_i,
    output logic [3:0] s_o
);
    localparam logic [0:63][3:0] TABLE = {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
                                          64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453};
    logic [5:0] addr;
    assign addr = {b_i[5], b_i[0], b_i[4:1]};
    assign s_o  = TABLE[addr];
endmodule

module sbox6 (
    input  logic [5:0] b_i,
    output logic [3:0] s_o
);
    localparam logic [0:63][3:0] TABLE = {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
                                          64'h9EF528C3704A1DB6, 64'h432C95FABE17608D};
    logic [5:0] addr;
    assign addr = {b_i[5], b_i[0], b_i[4:1]};
    assign s_o  = TABLE[addr];
endmodule

module sbox7 (
    input  logic [5:0] b_i,
    output logic [3:0] s_o
);
    localparam logic [0:63][3:0] TABLE = {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
                                          64'h14BDC37EAF680592, 64'h6BD814A7950FE23C};
    logic [5:0] addr;
    assign addr = {b_i[5], b_i[0], b_i[4:1]};
    assign s_o  = TABLE[addr];
endmodule

module sbox8 (
    input  logic [5:0] b_i,
    output logic [3:0] s_o
);
    localparam logic [0:63][3:0] TABLE = {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
                                          64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};
    logic [5:0] addr;
    assign addr = {b_i[5], b_i[0], b_i[4:1]};
    assign s_o  = TABLE[addr];
endmodule

// File: rtl/des_f_pipe.sv
// des_f_pipe: two-stage pipelined DES round function f(R, K) with valid/ready
// handshake and an uninterpreted sideband tag travelling with each item.
//   clk, rst          - clock, synchronous active-high reset
//   in_valid/in_ready - input handshake; in_ready depends on out_ready only
//   r_in [31:0]       - right half R (bit 31 = DES bit 1)
//   subkey [47:0]     - round key K (bit 47 = DES bit 1)
//   tag_in [TAG_W-1:0]- sideband carried to tag_out
//   out_valid/out_ready - output handshake
//   f_out [31:0]      - f(R, K) (bit 31 = DES bit 1)
//   tag_out           - tag_in of the same item
// Stage 1 holds E(R) ^ K, stage 2 holds P(S(stage 1)).
module des_f_pipe
    import des_pkg::*;
#(
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [R_W-1:0]   r_in,
    input  logic [K_W-1:0]   subkey,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [R_W-1:0]   f_out,
    output logic [TAG_W-1:0] tag_out
);

    logic             s1Valid_q, s1Valid_d;
    logic [K_W-1:0]   s1X_q, s1X_d;
    logic [TAG_W-1:0] s1Tag_q, s1Tag_d;
    logic             s2Valid_q, s2Valid_d;
    logic [R_W-1:0]   fOut_q, fOut_d;
    logic [TAG_W-1:0] tagOut_q, tagOut_d;

    logic             s1Adv;
    logic             s2Adv;
    logic [R_W-1:0]   sLayer;

    // A stage may load when it is empty or its contents move on this cycle,
    // so an empty stage 2 pulls stage 1 forward even while the consumer stalls.
    assign s2Adv    = !s2Valid_q || out_ready;
    assign s1Adv    = !s1Valid_q || s2Adv;
    assign in_ready = s1Adv;

    des_sbox_layer uSboxLayer (
        .x_i (s1X_q),
        .s_o (sLayer)
    );

    // Next-state selection: data registers only load when their stage
    // advances with a valid item behind it, otherwise everything holds.
    always_comb begin
        s1Valid_d = s1Valid_q;
        s1X_d     = s1X_q;
        s1Tag_d   = s1Tag_q;
        s2Valid_d = s2Valid_q;
        fOut_d    = fOut_q;
        tagOut_d  = tagOut_q;

        if (s1Adv) begin
            s1Valid_d = in_valid;
            if (in_valid) begin
                s1X_d   = des_expand(r_in) ^ subkey;
                s1Tag_d = tag_in;
            end
        end

        if (s2Adv) begin
            s2Valid_d = s1Valid_q;
            if (s1Valid_q) begin
                fOut_d   = des_perm_p(sLayer);
                tagOut_d = s1Tag_q;
            end
        end
    end

    // Reset clears every stage and wins over any handshake in the same cycle,
    // dropping whatever was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1X_q     <= '0;
            s1Tag_q   <= '0;
            s2Valid_q <= 1'b0;
            fOut_q    <= '0;
            tagOut_q  <= '0;
        end else begin
            s1Valid_q <= s1Valid_d;
            s1X_q     <= s1X_d;
            s1Tag_q   <= s1Tag_d;
            s2Valid_q <= s2Valid_d;
            fOut_q    <= fOut_d;
            tagOut_q  <= tagOut_d;
        end
    end

    assign out_valid = s2Valid_q;
    assign f_out     = fOut_q;
    assign tag_out   = tagOut_q;

endmodule

// File: doc/des_f_pipe.md
Name: des_f_pipe

Overview:
- Two-stage pipelined DES round function f(R, K) with a valid/ready handshake and a sideband tag carried alongside each item.
- Stage 1 registers the E-expansion of the 32-bit right half XORed with the 48-bit subkey.
- Stage 2 registers the P-permuted output of the eight existing S-box modules, sbox1..sbox8.
- Sits between the subkey scheduler/round controller and the L-XOR/swap logic of the round datapath.

Parameters:
- TAG_W, 32, width of the sideband tag carried with each item (the round controller uses it for L-half passthrough); minimum 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input item present.
- in_ready  out  1  stage 1 can accept an item this cycle.
- r_in  in  32  right half R; bit 31 = DES bit 1.
- subkey  in  48  round key K; bit 47 = DES bit 1.
- tag_in  in  TAG_W  sideband, not interpreted.
- out_valid  out  1  f result present.
- out_ready  in  1  consumer accepts the result this cycle.
- f_out  out  32  f(R, K); bit 31 = DES bit 1.
- tag_out  out  TAG_W  tag_in of the same item.

Behaviour:
- Reset: s1_valid = 0 and out_valid = 0 (s2_valid). f_out, tag_out and the stage-1 data registers reset to 0. Reset overrides any simultaneous handshake.
- Reset mid-operation drops all in-flight items. No output is produced for them.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stage advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, which is combinational from out_ready. No combinational path from in_valid to in_ready.
- Stage 1, on s1_adv:
  - s1_valid <= in_valid.
  - When in_valid, s1_x <= E(r_in) ^ subkey and s1_tag <= tag_in.
  - E is the standard DES expansion table. Output DES bit j takes input DES bit E[j].
- Stage 2, on s2_adv:
  - s2_valid <= s1_valid.
  - When s1_valid, f_out <= P(S(s1_x)) and tag_out <= s1_tag.
- S-box layer:
  - sbox i (1..8) receives s1_x[47-6(i-1) -: 6]; sbox1 gets [47:42], sbox8 gets [5:0].
  - Each box is indexed row = {b5, b0}, column = b4..b1.
  - The 4-bit results are concatenated with sbox1 at [31:28] and sbox8 at [3:0].
- P is the standard DES 32-bit permutation.
- Data registers hold their value when the stage does not advance. Outputs stay stable while out_valid && !out_ready.
- Latency: 2 cycles from input transfer to out_valid, with no stalls.
- Throughput: 1 item/cycle with out_ready held high. Capacity: 2 items.
- Full pipeline with out_ready = 0: in_ready = 0 and inputs are ignored.
- Full pipeline with out_ready = 1 and in_valid = 1: simultaneous output and input transfer; all stages shift.
- Bubbles are squeezed: a valid stage-1 item moves into an empty stage 2 even while stage 2 is stalled downstream.
- No data-dependent timing.

Decomposition:
- Package des_pkg:
  - E_TABLE (48 entries) and P_TABLE (32 entries) as constant arrays.
  - Helper functions des_expand(32→48) and des_perm_p(32→32), both using DES 1-based MSB-first numbering.
- Sub-module des_sbox_layer: combinational 48→32, instantiating sbox1..sbox8 unchanged; des_f_pipe adds the registers and handshake around it.

Test Plan:
- Zero vector: r_in = 0x00000000, subkey = 0 with out_ready = 1.
  - Required: f_out = 0xD8D8DBBC exactly 2 cycles after the transfer.
  - S-layer pre-P value = 0xEFA72C4D, with sbox8 seeing input 6'b000000 → 13.
- FIPS round 1: r_in = 0xF0AAF0AA, subkey = 0x1B02EFFC7072, tag = 0xCC00CCFF.
  - Stage-1 register = 0x6117BA866527 (E(r_in) = 0x7A15557A1555).
  - S-layer = 0x5C82B597; f_out = 0x234AA9BB; tag_out = 0xCC00CCFF.
  - tag_out ^ f_out = 0xEF4A6544.
- Back-pressure: stream 4 distinct items with out_ready = 0 from cycle 0.
  - Required: in_ready falls after 2 accepts, and out_valid and f_out stay stable.
  - Required: releasing out_ready delivers all 4 in order with no loss or duplication.
- Full-rate stream: 16 random (R, K) pairs, in_valid and out_ready held 1.
  - Required: one result per cycle, matching a reference-model f, in order.
- Random in_valid / out_ready toggling over 1000 items: output sequence equals the input sequence; tags match.
- Reset with 2 items in flight: both out_valid and s1_valid are 0 the next cycle, and no result for those items ever appears.
  - Required: in_ready = 1 on the cycle after reset deasserts.
